// File: rtl/fraction_multiplier_param.sv
// Sequential two's-complement fractional multiplier, Q1.(W-1) x Q1.(W-1).
// Radix-2 add/shift with a subtract on the sign step; full and rounded results.
module fraction_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               St,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic [2*WIDTH-2:0] Product,
  output logic [WIDTH-1:0]   ProductRnd,
  output logic               Ovf,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-2:0] P_MAX = {1'b0, {(2*WIDTH-2){1'b1}}};
  localparam logic [WIDTH-1:0] R_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;

  logic             last;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_sum;
  logic [WIDTH:0]   a_sel;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [2*WIDTH-1:0] raw;
  logic             sat;
  logic [2*WIDTH-2:0] prod_nxt;
  logic [WIDTH-1:0] hi;
  logic             rbit;
  logic             rnd_sat;
  logic [WIDTH-1:0] rnd_nxt;

  assign last  = (cnt_q == LAST);
  assign m_ext = {m_q[WIDTH-1], m_q};

  // Sign bit of the multiplier carries weight -1, hence subtract on the last step
  always_comb begin
    a_sum = last ? (a_q - m_ext) : (a_q + m_ext);
    a_sel = b_q[0] ? a_sum : a_q;
    a_nxt = {a_sel[WIDTH], a_sel[WIDTH:1]};
    b_nxt = {a_sel[0], b_q[WIDTH-1:1]};
  end

  assign raw = {a_nxt[WIDTH-1:0], b_nxt};

  // Only -1 x -1 reaches +1.0, where the two top raw bits disagree
  assign sat      = raw[2*WIDTH-1] ^ raw[2*WIDTH-2];
  assign prod_nxt = sat ? P_MAX : raw[2*WIDTH-2:0];

  assign hi      = prod_nxt[2*WIDTH-2:WIDTH-1];
  assign rbit    = prod_nxt[WIDTH-2];
  assign rnd_sat = (hi == R_MAX) && rbit;
  assign rnd_nxt = rnd_sat ? R_MAX : hi + WIDTH'(rbit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (St) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      Product    <= '0;
      ProductRnd <= '0;
      Ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            a_q   <= '0;
            b_q   <= Mplier;
            m_q   <= Mcand;
            cnt_q <= '0;
          end
        end
        CALC: begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            Product    <= prod_nxt;
            ProductRnd <= rnd_nxt;
            Ovf        <= sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_fraction_multiplier_param.sv
// Scoreboard bench for fraction_multiplier_param at WIDTH 4 and 8.
// Stimulus pushes expected results; per-instance monitors pop on Done.
module tb_fraction_multiplier_param;

  logic       clk;
  logic       rst;
  logic       st4, st8;
  logic [3:0] mp4, mc4;
  logic [7:0] mp8, mc8;
  logic [6:0]  p4;
  logic [3:0]  r4;
  logic [14:0] p8;
  logic [7:0]  r8;
  logic o4, o8, busy4, busy8, done4, done8;

  int n_chk;
  int n_pass;
  int cyc;

  typedef struct {
    logic [31:0] p;
    logic [31:0] r;
    logic        o;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  fraction_multiplier_param #(.WIDTH(4)) u4 (
    .CLK(clk), .RST(rst), .St(st4),
    .Mplier(mp4), .Mcand(mc4),
    .Product(p4), .ProductRnd(r4), .Ovf(o4),
    .Busy(busy4), .Done(done4)
  );

  fraction_multiplier_param #(.WIDTH(8)) u8 (
    .CLK(clk), .RST(rst), .St(st8),
    .Mplier(mp8), .Mcand(mc8),
    .Product(p8), .ProductRnd(r8), .Ovf(o8),
    .Busy(busy8), .Done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        chk("w4 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("w4 product", 32'(p4), e.p);
        chk("w4 rnd", 32'(r4), e.r);
        chk("w4 ovf", 32'(o4), 32'(e.o));
        chk("w4 latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8 product", 32'(p8), e.p);
        chk("w8 rnd", 32'(r8), e.r);
        chk("w8 ovf", 32'(o8), 32'(e.o));
        chk("w8 latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge with the target instance idle
  task automatic issue(input bit w8, input logic [7:0] mp, input logic [7:0] mc,
                       input logic [31:0] p, input logic [31:0] r, input logic o);
    exp_t e;
    e.p = p;
    e.r = r;
    e.o = o;
    e.cyc = cyc + 1 + (w8 ? 8 : 4);
    if (w8) begin
      st8 = 1'b1; mp8 = mp; mc8 = mc;
      q8.push_back(e);
    end else begin
      st4 = 1'b1; mp4 = mp[3:0]; mc4 = mc[3:0];
      q4.push_back(e);
    end
    @(negedge clk);
    st4 = 1'b0;
    st8 = 1'b0;
    mp4 = 4'h5; mc4 = 4'hA;
    mp8 = 8'h5A; mc8 = 8'hA5;
  endtask

  task automatic wait_idle(input bit w8);
    int n;
    n = 0;
    while ((w8 ? busy8 : busy4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("wait idle timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int c;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    st4 = 1'b0; st8 = 1'b0;
    mp4 = '0; mc4 = '0; mp8 = '0; mc8 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy4", 32'(busy4), 32'd0);
    chk("reset done4", 32'(done4), 32'd0);
    chk("reset p4", 32'(p4), 32'd0);
    chk("reset r4", 32'(r4), 32'd0);
    chk("reset o4", 32'(o4), 32'd0);
    chk("reset busy8", 32'(busy8), 32'd0);
    chk("reset p8", 32'(p8), 32'd0);
    chk("reset r8", 32'(r8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 8'h4, 8'h4, 32'h10, 32'h2, 1'b0); wait_idle(0);
    issue(0, 8'hC, 8'h6, 32'h68, 32'hD, 1'b0); wait_idle(0);
    issue(0, 8'h8, 8'h8, 32'h3F, 32'h7, 1'b1); wait_idle(0);
    issue(0, 8'h1, 8'h5, 32'h05, 32'h1, 1'b0); wait_idle(0);
    issue(0, 8'h7, 8'h7, 32'h31, 32'h6, 1'b0); wait_idle(0);

    issue(1, 8'h80, 8'h40, 32'h6000, 32'hC0, 1'b0); wait_idle(1);
    issue(1, 8'h40, 8'h40, 32'h1000, 32'h20, 1'b0); wait_idle(1);
    issue(1, 8'h80, 8'h80, 32'h3FFF, 32'h7F, 1'b1); wait_idle(1);
    issue(1, 8'h01, 8'h41, 32'h0041, 32'h01, 1'b0); wait_idle(1);
    issue(1, 8'hFF, 8'h40, 32'h7FC0, 32'h00, 1'b0); wait_idle(1);

    // Abort a W=8 run with reset on its third step
    st8 = 1'b1; mp8 = 8'h12; mc8 = 8'h34;
    @(negedge clk);
    st8 = 1'b0;
    chk("calc busy8", 32'(busy8), 32'd1);
    chk("calc hold p8", 32'(p8), 32'h7FC0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy8", 32'(busy8), 32'd0);
    chk("abort done8", 32'(done8), 32'd0);
    chk("abort p8", 32'(p8), 32'd0);
    chk("abort r8", 32'(r8), 32'd0);
    chk("abort o8", 32'(o8), 32'd0);
    repeat (12) @(negedge clk);

    // St held high across a run: ignored in CALC/DONE, re-accepted in IDLE
    begin
      exp_t e1, e2;
      c = cyc;
      e1.p = 32'h10; e1.r = 32'h2; e1.o = 1'b0; e1.cyc = c + 5;
      e2.p = 32'h68; e2.r = 32'hD; e2.o = 1'b0; e2.cyc = c + 11;
      q4.push_back(e1);
      q4.push_back(e2);
      st4 = 1'b1; mp4 = 4'h4; mc4 = 4'h4;
      @(negedge clk);
      mp4 = 4'hC; mc4 = 4'h6;
      repeat (6) @(negedge clk);
      st4 = 1'b0;
      wait_idle(0);
    end

    issue(1, 8'h40, 8'h40, 32'h1000, 32'h20, 1'b0); wait_idle(1);

    repeat (5) @(negedge clk);
    chk("w4 queue drained", 32'(q4.size()), 32'd0);
    chk("w8 queue drained", 32'(q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
